gray_ptr_gen: RTL



---
 rtl/gray_pkg.sv | 21 ++
 rtl/b2g_enc.sv | 16 +
 rtl/gray_ptr_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code constants and conversion helpers
package gray_pkg;

  localparam int GRAY_DEF_WIDTH = 4;
  localparam int GRAY_MAX_WIDTH = 16;

  // Operands are zero-extended to GRAY_MAX_WIDTH; narrower callers truncate the result.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/b2g_enc.sv
// rtl/b2g_enc.sv - combinational WIDTH-wide binary-to-Gray encoder
module b2g_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  logic [GRAY_MAX_WIDTH-1:0] w_gray_full;

  assign w_gray_full = bin2gray(GRAY_MAX_WIDTH'(i_bin));
  assign o_gray      = w_gray_full[WIDTH-1:0];

endmodule

// File: rtl/gray_ptr_gen.sv
// rtl/gray_ptr_gen.sv - registered binary/Gray pointer counter with wrap and end flags
// Optional sticky one-bit-change checker and err port enabled by GRAY_CHK_EN.
module gray_ptr_gen
  import gray_pkg::*;
#(
  parameter int              WIDTH    = GRAY_DEF_WIDTH,
  parameter bit              SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             at_end
`ifdef GRAY_CHK_EN
  ,
  output logic             err
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RST_VAL)));

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_at_end;

  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  logic             w_at_end_next;
  logic             w_step;

  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    w_step      = 1'b0;
    if (load) begin
      w_bin_next = load_bin;
    end else if (inc_en) begin
      if (dir) begin
        if (r_bin != MAX_VAL) begin
          w_bin_next = r_bin + 1'b1;
          w_step     = 1'b1;
        end else if (!SATURATE) begin
          w_bin_next  = '0;
          w_wrap_next = 1'b1;
          w_step      = 1'b1;
        end
      end else begin
        if (r_bin != '0) begin
          w_bin_next = r_bin - 1'b1;
          w_step     = 1'b1;
        end else if (!SATURATE) begin
          w_bin_next  = MAX_VAL;
          w_wrap_next = 1'b1;
          w_step      = 1'b1;
        end
      end
    end
    w_at_end_next = dir ? (w_bin_next == MAX_VAL) : (w_bin_next == '0);
  end

  // Gray is encoded from the next binary value so bin and gray never disagree.
  b2g_enc #(.WIDTH(WIDTH)) u_b2g_enc (
    .i_bin  (w_bin_next),
    .o_gray (w_gray_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin    <= RST_VAL;
      r_gray   <= RST_GRAY;
      r_wrap   <= 1'b0;
      r_at_end <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
      if (inc_en || load) begin
        r_at_end <= w_at_end_next;
      end
    end
  end

  assign bin    = r_bin;
  assign gray   = r_gray;
  assign wrap   = r_wrap;
  assign at_end = r_at_end;

`ifdef GRAY_CHK_EN
  logic [WIDTH-1:0] r_gray_prev;
  logic             r_chk_pend;
  logic             r_err;
  logic             w_err_set;

  // r_chk_pend marks that r_gray was just produced by a counting step, not a load.
  assign w_err_set = r_chk_pend && ($countones(r_gray ^ r_gray_prev) != 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gray_prev <= RST_GRAY;
      r_chk_pend  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_gray_prev <= r_gray;
      r_chk_pend  <= w_step;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
`ifndef SYNTHESIS
      if (w_err_set && !r_err) begin
        $error("gray_ptr_gen: gray step changed %0d bits", $countones(r_gray ^ r_gray_prev));
      end
`endif
    end
  end

  assign err = r_err;
`endif

endmodule
